// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the RV32I datapath and the hazard/sequencing controller.
// The datapath is the master: it supplies register ids and memory status and consumes enables, clears and forwarding selects.
interface hazard_ctrl_if;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic [1:0] ResultSrc_e;
    logic       PCSrc_e;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       RegWrite_m;
    logic       RegWrite_w;
    logic       dmem_req_m;
    logic       dmem_ready;

    logic       enable_f;
    logic       enable_fd;
    logic       enable_de;
    logic       enable_em;
    logic       enable_mw;
    logic       clear_fd;
    logic       clear_de;
    logic       clear_em;
    logic       clear_mw;
    logic [1:0] ForwardA_e;
    logic [1:0] ForwardB_e;
    logic       mem_err;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, ResultSrc_e, PCSrc_e,
               rd_m, rd_w, RegWrite_m, RegWrite_w, dmem_req_m, dmem_ready,
        input  enable_f, enable_fd, enable_de, enable_em, enable_mw,
               clear_fd, clear_de, clear_em, clear_mw,
               ForwardA_e, ForwardB_e, mem_err
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, ResultSrc_e, PCSrc_e,
               rd_m, rd_w, RegWrite_m, RegWrite_w, dmem_req_m, dmem_ready,
        output enable_f, enable_fd, enable_de, enable_em, enable_mw,
               clear_fd, clear_de, clear_em, clear_mw,
               ForwardA_e, ForwardB_e, mem_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/forward decode plus a data-memory wait FSM with timeout watchdog.
// Outputs are combinational (zero latency); HALT freezes the pipe until rst. Optional counters: HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 10
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_flush_cnt,
    output logic [31:0]  perf_lu_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic halt_act;
    logic mem_stall;
    logic lu_hit;
    logic flush_act;
    logic lu_act;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m,
                                           input logic [4:0] rd_m,
                                           input logic       wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (hif.dmem_req_m && !hif.dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hif.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // While rst is high the decode behaves as if the FSM were already in RUN.
    always_comb begin
        halt_act  = (state_q == HALT) && !rst;
        mem_stall = !halt_act && hif.dmem_req_m && !hif.dmem_ready;
        lu_hit    = (hif.ResultSrc_e == 2'b01) && (hif.rd_e != 5'd0) &&
                    ((hif.rd_e == hif.rs1_d) || (hif.rd_e == hif.rs2_d));
        flush_act = !halt_act && !mem_stall && hif.PCSrc_e;
        lu_act    = !halt_act && !mem_stall && !hif.PCSrc_e && lu_hit;

        hif.enable_f  = 1'b1;
        hif.enable_fd = 1'b1;
        hif.enable_de = 1'b1;
        hif.enable_em = 1'b1;
        hif.enable_mw = 1'b1;
        hif.clear_fd  = 1'b0;
        hif.clear_de  = 1'b0;
        hif.clear_em  = 1'b0;
        hif.clear_mw  = 1'b0;

        if (halt_act || mem_stall) begin
            hif.enable_f  = 1'b0;
            hif.enable_fd = 1'b0;
            hif.enable_de = 1'b0;
            hif.enable_em = 1'b0;
            hif.enable_mw = 1'b0;
        end else if (flush_act) begin
            hif.clear_fd = 1'b1;
            hif.clear_de = 1'b1;
        end else if (lu_act) begin
            hif.enable_f  = 1'b0;
            hif.enable_fd = 1'b0;
            hif.clear_de  = 1'b1;
        end

        hif.ForwardA_e = fwd_sel(hif.rs1_e, hif.RegWrite_m, hif.rd_m, hif.RegWrite_w, hif.rd_w);
        hif.ForwardB_e = fwd_sel(hif.rs2_e, hif.RegWrite_m, hif.rd_m, hif.RegWrite_w, hif.rd_w);
        hif.mem_err    = mem_err_q;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_lu_q, perf_lu_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, mem_stall};
        perf_flush_d = perf_flush_q + {31'd0, flush_act};
        perf_lu_d    = perf_lu_q + {31'd0, lu_act};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_lu_q    <= perf_lu_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_lu_cnt    = perf_lu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4): directed scenarios plus a randomized run against a behavioural model.
module tb_hazard_ctrl;
    localparam int TO = 4;

    // {enable_f, enable_fd, enable_de, enable_em, enable_mw, clear_fd, clear_de, clear_em, clear_mw}
    localparam logic [8:0] C_RUN    = 9'b11111_0000;
    localparam logic [8:0] C_FREEZE = 9'b00000_0000;
    localparam logic [8:0] C_FLUSH  = 9'b11111_1100;
    localparam logic [8:0] C_LU     = 9'b00111_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;
    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .hif(hif),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_lu_cnt(perf_lu_cnt));
`else
    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(10)) dut (.clk(clk), .rst(rst), .hif(hif));
`endif

    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_now();
        return {hif.enable_f, hif.enable_fd, hif.enable_de, hif.enable_em, hif.enable_mw,
                hif.clear_fd, hif.clear_de, hif.clear_em, hif.clear_mw};
    endfunction

    // Reference rules stated directly: freeze beats flush beats load-use.
    function automatic logic [8:0] exp_ctrl(input logic halted, input logic stall,
                                            input logic br, input logic lu);
        if (halted || stall) return C_FREEZE;
        if (br)              return C_FLUSH;
        if (lu)              return C_LU;
        return C_RUN;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                           input logic ww, input logic [4:0] rdw);
        if (rs == 5'd0)              return 2'b00;
        if (wm && rdm == rs)         return 2'b10;
        if (ww && rdw == rs)         return 2'b01;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hif.rs1_d = 5'd1; hif.rs2_d = 5'd2; hif.rs1_e = 5'd3; hif.rs2_e = 5'd4;
        hif.rd_e = 5'd0; hif.ResultSrc_e = 2'b00; hif.PCSrc_e = 1'b0;
        hif.rd_m = 5'd0; hif.rd_w = 5'd0; hif.RegWrite_m = 1'b0; hif.RegWrite_w = 1'b0;
        hif.dmem_req_m = 1'b0; hif.dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        hif.ResultSrc_e = 2'b01; hif.rd_e = 5'd9; hif.rs1_d = 5'd9;
        #2;
        checks++;
        if (ctrl_now() !== C_LU) begin
            errors++; $display("FAIL rst_decode got %b exp %b", ctrl_now(), C_LU);
        end
        tick();
        rst = 1'b0;
        set_idle();
        #2;
        checks++;
        if (ctrl_now() !== C_RUN) begin
            errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl_now(), C_RUN);
        end
        checks++;
        if (hif.mem_err !== 1'b0 || hif.ForwardA_e !== 2'b00 || hif.ForwardB_e !== 2'b00) begin
            errors++; $display("FAIL reset_out err %b fa %b fb %b exp 0 00 00", hif.mem_err, hif.ForwardA_e, hif.ForwardB_e);
        end
        tick();
    endtask

    task automatic test_forwarding();
        set_idle();
        hif.rd_m = 5'd5; hif.rd_w = 5'd5; hif.rs1_e = 5'd5; hif.RegWrite_m = 1'b1; hif.RegWrite_w = 1'b1;
        #2; checks++;
        if (hif.ForwardA_e !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got %b exp 10", hif.ForwardA_e); end
        hif.RegWrite_m = 1'b0;
        #2; checks++;
        if (hif.ForwardA_e !== 2'b01) begin errors++; $display("FAIL fwd_w got %b exp 01", hif.ForwardA_e); end
        hif.rs1_e = 5'd0; hif.rd_w = 5'd0; hif.RegWrite_m = 1'b1; hif.rd_m = 5'd0;
        #2; checks++;
        if (hif.ForwardA_e !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", hif.ForwardA_e); end
        hif.rs2_e = 5'd12; hif.rd_m = 5'd12; hif.rd_w = 5'd12; hif.RegWrite_m = 1'b0; hif.RegWrite_w = 1'b1;
        #2; checks++;
        if (hif.ForwardB_e !== 2'b01) begin errors++; $display("FAIL fwd_b_w got %b exp 01", hif.ForwardB_e); end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        hif.ResultSrc_e = 2'b01; hif.rd_e = 5'd7; hif.rs2_d = 5'd7;
        #2; checks++;
        if (ctrl_now() !== C_LU) begin errors++; $display("FAIL load_use got %b exp %b", ctrl_now(), C_LU); end
        tick();
        hif.rd_e = 5'd0; hif.rs2_d = 5'd0;
        #2; checks++;
        if (ctrl_now() !== C_RUN) begin errors++; $display("FAIL load_use_x0 got %b exp %b", ctrl_now(), C_RUN); end
        hif.rd_e = 5'd7; hif.rs2_d = 5'd7; hif.ResultSrc_e = 2'b00;
        #2; checks++;
        if (ctrl_now() !== C_RUN) begin errors++; $display("FAIL non_load got %b exp %b", ctrl_now(), C_RUN); end
        tick();
    endtask

    task automatic test_flush_vs_lu();
        set_idle();
        hif.ResultSrc_e = 2'b01; hif.rd_e = 5'd7; hif.rs1_d = 5'd7; hif.PCSrc_e = 1'b1;
        #2; checks++;
        if (ctrl_now() !== C_FLUSH) begin errors++; $display("FAIL flush_over_lu got %b exp %b", ctrl_now(), C_FLUSH); end
        tick();
    endtask

    task automatic test_mem_wait();
        set_idle();
        hif.dmem_req_m = 1'b1; hif.dmem_ready = 1'b0; hif.PCSrc_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2; checks++;
            if (ctrl_now() !== C_FREEZE) begin errors++; $display("FAIL wait_freeze[%0d] got %b exp %b", i, ctrl_now(), C_FREEZE); end
            tick();
        end
        hif.dmem_ready = 1'b1;
        #2; checks++;
        if (ctrl_now() !== C_FLUSH) begin errors++; $display("FAIL wait_release got %b exp %b", ctrl_now(), C_FLUSH); end
        tick();
        // Back in RUN: a fresh wait lasting TO cycles must not trip the watchdog.
        hif.PCSrc_e = 1'b0; hif.dmem_ready = 1'b0;
        repeat (TO) tick();
        hif.dmem_ready = 1'b1;
        #2; checks++;
        if (ctrl_now() !== C_RUN || hif.mem_err !== 1'b0) begin
            errors++; $display("FAIL wait_rearm got %b err %b exp %b err 0", ctrl_now(), hif.mem_err, C_RUN);
        end
        tick();
        set_idle();
    endtask

    task automatic test_timeout();
        set_idle();
        hif.dmem_req_m = 1'b1;
        repeat (TO) tick();
        #2; checks++;
        if (hif.mem_err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", hif.mem_err); end
        tick();
        #2; checks++;
        if (hif.mem_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", hif.mem_err); end
        hif.dmem_ready = 1'b1; hif.PCSrc_e = 1'b1;
        hif.rs1_e = 5'd8; hif.rd_m = 5'd8; hif.RegWrite_m = 1'b1;
        #2; checks++;
        if (ctrl_now() !== C_FREEZE) begin errors++; $display("FAIL halt_hold got %b exp %b", ctrl_now(), C_FREEZE); end
        checks++;
        if (hif.ForwardA_e !== 2'b10) begin errors++; $display("FAIL halt_fwd got %b exp 10", hif.ForwardA_e); end
        tick();
        rst = 1'b1;
        #2; checks++;
        if (ctrl_now() !== C_FLUSH) begin errors++; $display("FAIL rst_in_halt got %b exp %b", ctrl_now(), C_FLUSH); end
        tick();
        rst = 1'b0;
        set_idle();
        #2; checks++;
        if (hif.mem_err !== 1'b0 || ctrl_now() !== C_RUN) begin
            errors++; $display("FAIL rst_recover err %b ctrl %b exp 0 %b", hif.mem_err, ctrl_now(), C_RUN);
        end
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        rst = 1'b1; set_idle(); tick(); rst = 1'b0;
        hif.dmem_req_m = 1'b1;
        repeat (3) tick();
        hif.dmem_ready = 1'b1; tick();
        set_idle(); hif.PCSrc_e = 1'b1;
        repeat (2) tick();
        set_idle(); hif.ResultSrc_e = 2'b01; hif.rd_e = 5'd6; hif.rs1_d = 5'd6;
        tick();
        set_idle(); #2;
        checks++;
        if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd2 || perf_lu_cnt !== 32'd1) begin
            errors++; $display("FAIL perf_counts got %0d %0d %0d exp 3 2 1", perf_stall_cnt, perf_flush_cnt, perf_lu_cnt);
        end
        rst = 1'b1; tick(); rst = 1'b0; #2;
        checks++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0 || perf_lu_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_reset got %0d %0d %0d exp 0 0 0", perf_stall_cnt, perf_flush_cnt, perf_lu_cnt);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        bit halted = 1'b0, err = 1'b0, waiting = 1'b0;
        int not_ready_run = 0;
        int halt_age = 0;
        int mism = 0;
        int n_stall = 0, n_flush = 0, n_lu = 0;
        logic [8:0] exp_c;
        logic [1:0] efa, efb;
        bit stall, lu, eff_halt;
        rst = 1'b1; set_idle(); tick(); rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (halted && halt_age > 3) || ($urandom_range(0, 80) == 0);
            hif.rs1_d = 5'($urandom_range(0, 3)); hif.rs2_d = 5'($urandom_range(0, 3));
            hif.rs1_e = 5'($urandom_range(0, 3)); hif.rs2_e = 5'($urandom_range(0, 3));
            hif.rd_e  = 5'($urandom_range(0, 3)); hif.rd_m = 5'($urandom_range(0, 3));
            hif.rd_w  = 5'($urandom_range(0, 3));
            hif.ResultSrc_e = 2'($urandom_range(0, 3));
            hif.PCSrc_e    = ($urandom_range(0, 4) == 0);
            hif.RegWrite_m = 1'($urandom); hif.RegWrite_w = 1'($urandom);
            hif.dmem_req_m = waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
            hif.dmem_ready = ($urandom_range(0, 9) < 6);
            eff_halt = halted && !rst;
            stall = !eff_halt && hif.dmem_req_m && !hif.dmem_ready;
            lu = hif.ResultSrc_e == 2'b01 && hif.rd_e != 0 && (hif.rd_e == hif.rs1_d || hif.rd_e == hif.rs2_d);
            exp_c = exp_ctrl(eff_halt, stall, hif.PCSrc_e, lu);
            efa = exp_fwd(hif.rs1_e, hif.RegWrite_m, hif.rd_m, hif.RegWrite_w, hif.rd_w);
            efb = exp_fwd(hif.rs2_e, hif.RegWrite_m, hif.rd_m, hif.RegWrite_w, hif.rd_w);
            #2;
            checks++;
            if (ctrl_now() !== exp_c || hif.ForwardA_e !== efa || hif.ForwardB_e !== efb || hif.mem_err !== err) begin
                errors++;
                if (mism < 5)
                    $display("FAIL rand[%0d] ctrl %b fa %b fb %b err %b exp %b %b %b %b",
                             cyc, ctrl_now(), hif.ForwardA_e, hif.ForwardB_e, hif.mem_err, exp_c, efa, efb, err);
                mism++;
            end
            // Watchdog: halt once a wait has seen TO further not-ready cycles and still is not ready.
            if (rst) begin
                halted = 0; err = 0; waiting = 0; not_ready_run = 0; halt_age = 0;
                n_stall = 0; n_flush = 0; n_lu = 0;
            end else begin
                n_stall += int'(exp_c == C_FREEZE && !eff_halt);
                n_flush += int'(exp_c == C_FLUSH);
                n_lu    += int'(exp_c == C_LU);
                if (halted) halt_age++;
                else if (!waiting) begin
                    if (stall) begin waiting = 1; not_ready_run = 1; end
                end else if (hif.dmem_ready) begin
                    waiting = 0; not_ready_run = 0;
                end else if (not_ready_run == TO) begin
                    halted = 1; err = 1; halt_age = 0;
                end else not_ready_run++;
            end
            tick();
        end
`ifdef HAZARD_PERF_EN
        set_idle(); rst = 1'b0; #2;
        checks++;
        if (perf_stall_cnt !== 32'(n_stall) || perf_flush_cnt !== 32'(n_flush) || perf_lu_cnt !== 32'(n_lu)) begin
            errors++; $display("FAIL perf_rand got %0d %0d %0d exp %0d %0d %0d",
                               perf_stall_cnt, perf_flush_cnt, perf_lu_cnt, n_stall, n_flush, n_lu);
        end
`endif
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_flush_vs_lu();
        test_mem_wait();
        test_timeout();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
